// File: rtl/seg7_count_display.sv
// Binary-to-BCD (sequential double-dabble) converter driving a 4-digit
// multiplexed common-anode 7-segment display with a direction glyph.
module seg7_count_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  input  logic        ud,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_UP    = 7'b1000001;
  localparam logic [6:0] SEG_DOWN  = 7'b0100001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    last_value_reg, last_value_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic [11:0]   scratch_reg, scratch_next;
  logic [2:0]    iter_reg, iter_next;
  logic [11:0]   bcd_reg, bcd_next;
  logic          busy_reg, busy_next;
  logic          pending_reg, pending_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [1:0]    idx_reg, idx_next;
  logic [3:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;

  logic [11:0]   adj;
  logic [6:0]    dec [3];
  logic          scan_tc;

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h7F;
    endcase
  endfunction

  // Per-nibble add-3 correction and display decode of the committed result.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_nib
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                              scratch_reg[gi*4 +: 4] + 4'd3 :
                              scratch_reg[gi*4 +: 4];
      assign dec[gi] = seg_dec(bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    last_value_next = last_value_reg;
    shreg_next      = shreg_reg;
    scratch_next    = scratch_reg;
    iter_next       = iter_reg;
    bcd_next        = bcd_reg;
    busy_next       = busy_reg;
    pending_next    = pending_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg || (value != last_value_reg)) begin
          last_value_next = value;
          shreg_next      = value;
          scratch_next    = 12'h000;
          iter_next       = 3'd0;
          pending_next    = 1'b0;
          busy_next       = 1'b1;
          state_next      = SHIFT;
        end
      end
      SHIFT: begin
        scratch_next = {adj[10:0], shreg_reg[7]};
        shreg_next   = {shreg_reg[6:0], 1'b0};
        iter_next    = iter_reg + 3'd1;
        if (iter_reg == 3'd7) state_next = DONE;
      end
      DONE: begin
        bcd_next   = scratch_reg;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Scan: the digit index and its anode/pattern all change on the wrap edge.
  always_comb begin
    scan_tc    = (presc_reg == PRESC_TC);
    presc_next = scan_tc ? '0 : presc_reg + 1'b1;
    idx_next   = scan_tc ? idx_reg + 2'd1 : idx_reg;
    an_next    = an_reg;
    seg_next   = seg_reg;
    if (scan_tc) begin
      an_next = ~(4'b0001 << idx_next);
      case (idx_next)
        2'd0: seg_next = dec[0];
        2'd1: seg_next = (BLANK_LZ && bcd_reg[11:8] == 4'd0 && bcd_reg[7:4] == 4'd0) ?
                         SEG_BLANK : dec[1];
        2'd2: seg_next = (BLANK_LZ && bcd_reg[11:8] == 4'd0) ? SEG_BLANK : dec[2];
        default: seg_next = ud ? SEG_UP : SEG_DOWN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_value_reg <= 8'h00;
      shreg_reg      <= 8'h00;
      scratch_reg    <= 12'h000;
      iter_reg       <= 3'd0;
      bcd_reg        <= 12'h000;
      busy_reg       <= 1'b0;
      pending_reg    <= 1'b1;
      presc_reg      <= '0;
      idx_reg        <= 2'd0;
      an_reg         <= 4'hF;
      seg_reg        <= SEG_BLANK;
    end else begin
      state_reg      <= state_next;
      last_value_reg <= last_value_next;
      shreg_reg      <= shreg_next;
      scratch_reg    <= scratch_next;
      iter_reg       <= iter_next;
      bcd_reg        <= bcd_next;
      busy_reg       <= busy_next;
      pending_reg    <= pending_next;
      presc_reg      <= presc_next;
      idx_reg        <= idx_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
    end
  end

  assign seg  = seg_reg;
  assign an   = an_reg;
  assign bcd  = bcd_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed bench for seg7_count_display: conversion latency, scan order,
// blanking, direction glyph and asynchronous reset behaviour.
module tb_seg7_count_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  value;
  logic        ud;
  logic [6:0]  seg, seg0;
  logic [3:0]  an, an0;
  logic [11:0] bcd, bcd0;
  logic        busy, busy0;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  logic [6:0]  exp_seg  [4];
  logic [6:0]  exp_seg0 [4];

  always #5 clk = ~clk;

  seg7_count_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .ud(ud),
    .seg(seg), .an(an), .bcd(bcd), .busy(busy)
  );

  seg7_count_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .reset(reset), .value(value), .ud(ud),
    .seg(seg0), .an(an0), .bcd(bcd0), .busy(busy0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},  {5'd0, seg},  12'h07F);
    check({tag, "_an"},   {8'd0, an},   12'h00F);
    check({tag, "_bcd"},  bcd,          12'h000);
    check({tag, "_busy"}, {11'd0, busy}, 12'h000);
  endtask

  // Value was just applied in IDLE: busy after 1 edge, result after 10.
  task automatic conv_exact(input string tag);
    logic [11:0] e;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1 || i == 9) check({tag, "_busy_hi"}, {11'd0, busy}, 12'h001);
    end
    e = exp_q.pop_front();
    check({tag, "_busy_lo"}, {11'd0, busy}, 12'h000);
    check({tag, "_bcd"}, bcd, e);
    $display("conv %s: bcd=%h expected=%h", tag, bcd, e);
  endtask

  task automatic wait_busy_low(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_done"}, {11'd0, busy}, 12'h000);
  endtask

  task automatic wait_an(input logic [3:0] a, input string tag);
    int n = 0;
    while (an !== a && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_an_sync"}, {8'd0, an}, {8'd0, a});
  endtask

  task automatic scan_round(input string tag, input bit chk0);
    logic [3:0] a;
    repeat (16) tick();
    wait_an(4'hE, tag);
    for (int i = 0; i < 4; i++) begin
      a = 4'hF ^ (4'b0001 << i);
      check({tag, "_an"}, {8'd0, an}, {8'd0, a});
      check({tag, "_seg"}, {5'd0, seg}, {5'd0, exp_seg[i]});
      if (chk0) check({tag, "_seg_nolz"}, {5'd0, seg0}, {5'd0, exp_seg0[i]});
      $display("scan %s idx%0d: an=%h seg=%h", tag, i, an, seg);
      repeat (4) tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    value = 8'd0;
    ud    = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");

    reset = 1'b0;
    exp_q.push_back(12'h000);
    conv_exact("zero");
    exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h41};
    scan_round("zero", 1'b0);

    value = 8'd255;
    exp_q.push_back(12'h255);
    conv_exact("v255");
    exp_seg = '{7'h12, 7'h12, 7'h24, 7'h41};
    scan_round("v255", 1'b0);

    value = 8'd7;
    exp_q.push_back(12'h007);
    conv_exact("v7");
    exp_seg  = '{7'h78, 7'h7F, 7'h7F, 7'h41};
    exp_seg0 = '{7'h78, 7'h40, 7'h40, 7'h41};
    scan_round("v7", 1'b1);

    // Change arrives mid-conversion: first result stands, then reconvert.
    value = 8'd100;
    exp_q.push_back(12'h100);
    exp_q.push_back(12'h042);
    tick();
    check("v100_start", {11'd0, busy}, 12'h001);
    repeat (3) tick();
    value = 8'd42;
    wait_busy_low("v100");
    check("v100_bcd", bcd, exp_q.pop_front());
    $display("conv v100: bcd=%h", bcd);
    tick();
    check("v42_restart", {11'd0, busy}, 12'h001);
    wait_busy_low("v42");
    check("v42_bcd", bcd, exp_q.pop_front());
    $display("conv v42: bcd=%h", bcd);

    // Direction change while digit 3 is lit shows only on its next refresh.
    repeat (16) tick();
    wait_an(4'h7, "ud_a");
    ud = 1'b0;
    tick();
    check("ud_hold", {5'd0, seg}, 12'h041);
    repeat (4) tick();
    wait_an(4'h7, "ud_b");
    check("ud_down", {5'd0, seg}, 12'h021);
    $display("ud toggle: seg=%h", seg);

    // Reset in the middle of SHIFT clears everything without a clock edge.
    value = 8'd200;
    tick();
    tick();
    tick();
    check("rst_mid_busy", {11'd0, busy}, 12'h001);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    reset = 1'b0;
    exp_q.push_back(12'h200);
    conv_exact("v200");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
